mem_system: RTL and testbench
=============================

Name: mem_system

Overview:
- Word-wide (16-bit) memory system: 2-way set-associative, write-back, write-allocate cache in front of a behavioural 64 KiB backing memory.
- Serves one Rd/Wr request at a time to the processor pipeline, with a Stall/Done handshake and a CacheHit indication.
- Hits complete in 1 cycle; misses complete in 8 cycles (clean victim) or 12 cycles (dirty victim).

Parameters:
- SETS, 256, number of cache sets (index width 8).
- WORDS_PER_LINE, 4, 16-bit words per line (offset bits Addr[2:1]).
- MEM_LAT, 2, backing-memory read latency in cycles.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-low reset.
- Addr  in  16  byte address. Tag = Addr[15:11], index = Addr[10:3], word offset = Addr[2:1]. Addr[0] is ignored.
- DataIn  in  16  write data.
- Rd  in  1  read request.
- Wr  in  1  write request.
- createdump  in  1  simulation-only memory-dump hook; no effect on any output.
- DataOut  out  16  read data; valid only while Done=1 for a read.
- Done  out  1  one-cycle completion pulse for the current request.
- Stall  out  1  1 = busy; requester must not present a new request.
- CacheHit  out  1  valid with Done. 1 = the request hit without a memory access.

Behaviour:
- Reset (rst=0, asynchronous):
  - State goes to IDLE; any in-flight request is aborted and no Done is produced for it.
  - All valid and dirty bits clear; victim pointer = 0; backing memory clears to zero.
  - Outputs: Done=0, Stall=0, CacheHit=0, DataOut=0.
- Acceptance:
  - A request is accepted at a rising edge when (Rd|Wr)=1 and Stall=0.
  - On acceptance, Addr, DataIn and the op are registered. Rd&Wr both high is treated as a write.
  - The requester holds Rd/Wr until Done, then drops or replaces them.
- State machine: IDLE, COMPARE, WB0-WB3, RD0-RD3, WAIT, DONE.
- IDLE:
  - Stall=0.
  - Accept -> COMPARE.
- COMPARE (cycle after accept):
  - Tag-compare both ways of the indexed set.
  - Hit (valid & tag match in either way):
    - Done=1, CacheHit=1, Stall=0.
    - Read: DataOut = addressed word.
    - Write: word updated and dirty set at end of cycle.
    - Next state IDLE, or COMPARE again if a new request is accepted on this edge (back-to-back hits, 1 request per cycle).
  - Miss:
    - Stall=1.
    - Select victim: first invalid way (way0 before way1); if both ways are valid, use the victim pointer.
    - Victim valid & dirty -> WB0, else -> RD0.
- WB0-WB3: write victim words 0-3 to memory address {victim tag, index, word, 0}, one word per cycle -> RD0.
- RD0-RD3: issue reads of words 0-3 of the requested line.
  - Each word returns MEM_LAT cycles after issue and is written into the victim way.
  - RD3 -> WAIT.
- WAIT: MEM_LAT cycles for the last read to return.
  - At end: line valid, tag = request tag, dirty = 0.
  - Next state DONE.
- DONE:
  - Done=1, CacheHit=0, Stall=1.
  - Read: DataOut = requested word from the filled line.
  - Write: merge DataIn into the word and set dirty.
  - Next state IDLE.
- Latency (accept edge to the cycle with Done):
  - Hit = 1.
  - Clean miss = 1+4+2+1 = 8.
  - Dirty miss = 12.
  - Never exceeds 20; a miss never completes in 2 cycles or fewer.
- Victim pointer: toggles on every accepted request.
- Done, CacheHit and DataOut are combinational from the registered state.
- Done is never asserted without an accepted request, and exactly one Done is produced per accepted request.
- Coherence: DataOut always equals the last value written to that address (0 if never written), regardless of eviction history.

Test Plan:
- Reset, then Rd 0x0010 -> miss; Done 8 cycles after accept; DataOut=0x0000, CacheHit=0.
- Wr 0x0010 data 0x1234, then Rd 0x0010 -> write hit (1 cycle, CacheHit=1); read hit DataOut=0x1234 in 1 cycle; Stall=0 during both hits.
- Dirty eviction: Wr 0x0010=0xAAAA, Wr 0x0810=0xBBBB (same index, 2nd way), Wr 0x1010=0xCCCC -> third miss takes 12 cycles; then Rd 0x0010 returns 0xAAAA on a miss (or a hit if way still resident) with the correct value.
- Back-to-back hits on 4 words of one line (0x0020,0x0022,0x0024,0x0026) -> four consecutive Done pulses one cycle apart, all CacheHit=1.
- Reset asserted mid-miss (cycle 3 of WB) -> Stall=0 and Done=0 immediately; subsequent Rd to that address returns 0x0000.
- Random mixed Rd/Wr trace of 1000 requests against a flat-array model -> every read value matches, hit latency ≤2, miss latency in 3..20, request count = Done count.

Source files
------------

// File: rtl/mem_system.sv
// mem_system: 16-bit word memory system built from a 2-way set-associative,
// write-back, write-allocate cache and a behavioural 64 KiB backing memory.
// One request is in flight at a time; Stall/Done form the handshake.
module mem_system #(
  parameter int unsigned SETS           = 256,
  parameter int unsigned WORDS_PER_LINE = 4,
  parameter int unsigned MEM_LAT        = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] Addr,
  input  logic [15:0] DataIn,
  input  logic        Rd,
  input  logic        Wr,
  input  logic        createdump,
  output logic [15:0] DataOut,
  output logic        Done,
  output logic        Stall,
  output logic        CacheHit
);

  localparam int unsigned IDX_W     = $clog2(SETS);
  localparam int unsigned OFF_W     = $clog2(WORDS_PER_LINE);
  localparam int unsigned TAG_W     = 15 - IDX_W - OFF_W;
  localparam int unsigned LINE_W    = IDX_W + OFF_W;
  localparam int unsigned MEM_AW    = 15;
  localparam int unsigned MEM_WORDS = 32768;
  localparam int unsigned WAIT_W    = $clog2(MEM_LAT + 1);

  typedef enum logic [3:0] {
    S_IDLE,
    S_COMPARE,
    S_WB0, S_WB1, S_WB2, S_WB3,
    S_RD0, S_RD1, S_RD2, S_RD3,
    S_WAIT,
    S_DONE
  } state_e;

  // Control registers
  state_e            state_q, state_d;
  logic [15:0]       addr_q, addr_d;
  logic [15:0]       wdata_q, wdata_d;
  logic              wr_q, wr_d;
  logic              vptr_q, vptr_d;
  logic              way_q, way_d;
  logic [WAIT_W-1:0] wait_q, wait_d;

  // Backing-memory read return pipeline
  logic              rd_vld_q [MEM_LAT];
  logic              rd_vld_d [MEM_LAT];
  logic [OFF_W-1:0]  rd_off_q [MEM_LAT];
  logic [OFF_W-1:0]  rd_off_d [MEM_LAT];
  logic [15:0]       rd_dat_q [MEM_LAT];
  logic [15:0]       rd_dat_d [MEM_LAT];

  // Cache and backing storage
  logic [15:0]       line_data [2][SETS*WORDS_PER_LINE];
  logic [TAG_W-1:0]  tag_arr   [2][SETS];
  logic              valid_arr [2][SETS];
  logic              dirty_arr [2][SETS];
  logic [15:0]       mem       [MEM_WORDS];

  // Request fields
  logic [TAG_W-1:0]  req_tag;
  logic [IDX_W-1:0]  req_idx;
  logic [OFF_W-1:0]  req_off;

  logic              hit0, hit1, hit, hit_way, victim;
  logic              accept;
  logic [OFF_W-1:0]  beat;
  logic              mem_we, rd_issue, cw_en, cw_way, fill_en;
  logic              unused_sigs;

  assign req_tag = addr_q[15 -: TAG_W];
  assign req_idx = addr_q[LINE_W:OFF_W+1];
  assign req_off = addr_q[OFF_W:1];

  // The dump hook and the byte-select bit have no architectural effect
  assign unused_sigs = ^{createdump, addr_q[0]};

  // Tag compare of both ways and victim choice for the indexed set
  always_comb begin
    hit0    = valid_arr[0][req_idx] && (tag_arr[0][req_idx] == req_tag);
    hit1    = valid_arr[1][req_idx] && (tag_arr[1][req_idx] == req_tag);
    hit     = hit0 | hit1;
    hit_way = ~hit0;
    if (!valid_arr[0][req_idx])      victim = 1'b0;
    else if (!valid_arr[1][req_idx]) victim = 1'b1;
    else                             victim = vptr_q;
  end

  // Next-state, handshake outputs and storage write strobes
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    wr_d     = wr_q;
    vptr_d   = vptr_q;
    way_d    = way_q;
    wait_d   = wait_q;
    Done     = 1'b0;
    CacheHit = 1'b0;
    DataOut  = '0;
    Stall    = 1'b1;
    mem_we   = 1'b0;
    rd_issue = 1'b0;
    beat     = '0;
    cw_en    = 1'b0;
    cw_way   = way_q;
    fill_en  = 1'b0;
    case (state_q)
      S_IDLE: Stall = 1'b0;
      S_COMPARE: begin
        if (hit) begin
          Done     = 1'b1;
          CacheHit = 1'b1;
          Stall    = 1'b0;
          cw_way   = hit_way;
          if (wr_q) cw_en = 1'b1;
          else      DataOut = line_data[hit_way][{req_idx, req_off}];
          state_d  = S_IDLE;
        end else begin
          way_d = victim;
          if (valid_arr[victim][req_idx] && dirty_arr[victim][req_idx]) state_d = S_WB0;
          else                                                          state_d = S_RD0;
        end
      end
      S_WB0: begin mem_we = 1'b1; beat = OFF_W'(0); state_d = S_WB1; end
      S_WB1: begin mem_we = 1'b1; beat = OFF_W'(1); state_d = S_WB2; end
      S_WB2: begin mem_we = 1'b1; beat = OFF_W'(2); state_d = S_WB3; end
      S_WB3: begin mem_we = 1'b1; beat = OFF_W'(3); state_d = S_RD0; end
      S_RD0: begin rd_issue = 1'b1; beat = OFF_W'(0); state_d = S_RD1; end
      S_RD1: begin rd_issue = 1'b1; beat = OFF_W'(1); state_d = S_RD2; end
      S_RD2: begin rd_issue = 1'b1; beat = OFF_W'(2); state_d = S_RD3; end
      S_RD3: begin rd_issue = 1'b1; beat = OFF_W'(3); wait_d = '0; state_d = S_WAIT; end
      S_WAIT: begin
        wait_d = wait_q + WAIT_W'(1);
        // The last read lands on this same edge, so the line is complete here
        if (wait_q == WAIT_W'(MEM_LAT - 1)) begin
          fill_en = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        Done = 1'b1;
        if (wr_q) cw_en = 1'b1;
        else      DataOut = line_data[way_q][{req_idx, req_off}];
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    accept = (Rd | Wr) & ~Stall;
    if (accept) begin
      addr_d  = Addr;
      wdata_d = DataIn;
      wr_d    = Wr;
      vptr_d  = ~vptr_q;
      state_d = S_COMPARE;
    end
  end

  // Read return pipeline input: sample memory at issue, deliver MEM_LAT later
  always_comb begin
    rd_vld_d[0] = rd_issue;
    rd_off_d[0] = beat;
    rd_dat_d[0] = mem[{req_tag, req_idx, beat}];
    for (int unsigned s = 1; s < MEM_LAT; s++) begin
      rd_vld_d[s] = rd_vld_q[s-1];
      rd_off_d[s] = rd_off_q[s-1];
      rd_dat_d[s] = rd_dat_q[s-1];
    end
  end

  // Control state registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      wr_q    <= 1'b0;
      vptr_q  <= 1'b0;
      way_q   <= 1'b0;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wr_q    <= wr_d;
      vptr_q  <= vptr_d;
      way_q   <= way_d;
      wait_q  <= wait_d;
    end
  end

  // Read return pipeline registers; reset drops any reads still in flight
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned s = 0; s < MEM_LAT; s++) begin
        rd_vld_q[s] <= 1'b0;
        rd_off_q[s] <= '0;
        rd_dat_q[s] <= '0;
      end
    end else begin
      for (int unsigned s = 0; s < MEM_LAT; s++) begin
        rd_vld_q[s] <= rd_vld_d[s];
        rd_off_q[s] <= rd_off_d[s];
        rd_dat_q[s] <= rd_dat_d[s];
      end
    end
  end

  // Valid/dirty bits: cleared on reset, set by line fill and by write merges
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < SETS; i++) begin
        valid_arr[0][IDX_W'(i)] <= 1'b0;
        valid_arr[1][IDX_W'(i)] <= 1'b0;
        dirty_arr[0][IDX_W'(i)] <= 1'b0;
        dirty_arr[1][IDX_W'(i)] <= 1'b0;
      end
    end else begin
      if (fill_en) begin
        valid_arr[way_q][req_idx] <= 1'b1;
        dirty_arr[way_q][req_idx] <= 1'b0;
      end
      if (cw_en) dirty_arr[cw_way][req_idx] <= 1'b1;
    end
  end

  // Cache data and tag storage (only meaningful under a set valid bit)
  always_ff @(posedge clk) begin
    if (cw_en) line_data[cw_way][{req_idx, req_off}] <= wdata_q;
    if (rd_vld_q[MEM_LAT-1])
      line_data[way_q][{req_idx, rd_off_q[MEM_LAT-1]}] <= rd_dat_q[MEM_LAT-1];
    if (fill_en) tag_arr[way_q][req_idx] <= req_tag;
  end

  // Backing memory: cleared on reset, written by victim write-back
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < MEM_WORDS; i++) mem[MEM_AW'(i)] <= '0;
    end else if (mem_we) begin
      mem[{tag_arr[way_q][req_idx], req_idx, beat}] <= line_data[way_q][{req_idx, beat}];
    end
  end

endmodule

// File: tb/tb_mem_system.sv
// Directed bench for mem_system: miss/hit latency, dirty eviction, back-to-back
// hits, reset mid-miss, and a mixed request trace against a flat-array model.
module tb_mem_system;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] Addr, DataIn, DataOut;
  logic        Rd, Wr, createdump;
  logic        Done, Stall, CacheHit;

  int n_cmp = 0;
  int n_bad = 0;
  int done_cnt = 0;
  int req_cnt = 0;

  logic [15:0] model [32768];
  logic [15:0] b2b_val [4];

  mem_system #(.SETS(256), .WORDS_PER_LINE(4), .MEM_LAT(2)) dut (
    .clk(clk), .rst(rst), .Addr(Addr), .DataIn(DataIn), .Rd(Rd), .Wr(Wr),
    .createdump(createdump), .DataOut(DataOut), .Done(Done), .Stall(Stall),
    .CacheHit(CacheHit)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (rst === 1'b1 && Done === 1'b1) done_cnt++;

  initial begin
    #5000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Issue one request from IDLE, wait (bounded) for Done, return to IDLE.
  task automatic do_req(input logic [15:0] a, input logic wr, input logic [15:0] d,
                        output logic [15:0] rdata, output logic hit,
                        output logic stl, output int lat);
    Addr = a; DataIn = d; Wr = wr; Rd = ~wr;
    @(posedge clk); #1;
    Rd = 1'b0; Wr = 1'b0;
    lat = 1;
    while (Done !== 1'b1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    rdata = DataOut; hit = CacheHit; stl = Stall;
    if (Done !== 1'b1) lat = -1;
    req_cnt++;
    @(posedge clk); #1;
  endtask

  initial begin
    logic [15:0] rd;
    logic        h, s;
    int          lat, exp_lat;
    logic [15:0] a, d;
    logic        w;

    rst = 1'b0; Rd = 1'b0; Wr = 1'b0; createdump = 1'b0; Addr = '0; DataIn = '0;
    b2b_val[0] = 16'h1111; b2b_val[1] = 16'h2222;
    b2b_val[2] = 16'h3333; b2b_val[3] = 16'h4444;
    for (int i = 0; i < 32768; i++) model[i] = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_stall", Stall, 0);
    chk("rst_done", Done, 0);
    chk("rst_hit", CacheHit, 0);
    chk("rst_dout", DataOut, 0);
    rst = 1'b1;
    @(posedge clk); #1;

    // Cold read miss
    do_req(16'h0010, 1'b0, 16'h0, rd, h, s, lat);
    chk("miss_lat", lat, 8);
    chk("miss_data", rd, 16'h0000);
    chk("miss_hit", h, 0);
    chk("miss_stall", s, 1);

    // Write hit then read hit
    do_req(16'h0010, 1'b1, 16'h1234, rd, h, s, lat);
    chk("whit_lat", lat, 1);
    chk("whit_hit", h, 1);
    chk("whit_stall", s, 0);
    do_req(16'h0010, 1'b0, 16'h0, rd, h, s, lat);
    chk("rhit_lat", lat, 1);
    chk("rhit_hit", h, 1);
    chk("rhit_stall", s, 0);
    chk("rhit_data", rd, 16'h1234);

    // Dirty eviction in set 2
    do_req(16'h0010, 1'b1, 16'hAAAA, rd, h, s, lat);
    chk("ev_w0_lat", lat, 1);
    do_req(16'h0810, 1'b1, 16'hBBBB, rd, h, s, lat);
    chk("ev_w1_lat", lat, 8);
    do_req(16'h1010, 1'b1, 16'hCCCC, rd, h, s, lat);
    chk("ev_w2_lat", lat, 12);
    chk("ev_w2_hit", h, 0);
    do_req(16'h0010, 1'b0, 16'h0, rd, h, s, lat);
    chk("ev_r0_data", rd, 16'hAAAA);
    do_req(16'h0810, 1'b0, 16'h0, rd, h, s, lat);
    chk("ev_r1_data", rd, 16'hBBBB);
    do_req(16'h1011, 1'b0, 16'h0, rd, h, s, lat);
    chk("ev_r2_data", rd, 16'hCCCC);

    // Bring line 0x0020 in, then back-to-back writes and reads on its 4 words
    do_req(16'h0020, 1'b0, 16'h0, rd, h, s, lat);
    chk("b2b_fill_lat", lat, 8);
    Addr = 16'h0020; DataIn = b2b_val[0]; Wr = 1'b1; Rd = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      chk("b2b_w_done", Done, 1);
      chk("b2b_w_hit", CacheHit, 1);
      chk("b2b_w_stall", Stall, 0);
      if (k < 3) begin
        Addr = 16'h0020 + 16'(2 * (k + 1));
        DataIn = b2b_val[k+1];
      end else Wr = 1'b0;
      req_cnt++;
    end
    @(posedge clk); #1;
    Addr = 16'h0020; Rd = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      chk("b2b_r_done", Done, 1);
      chk("b2b_r_hit", CacheHit, 1);
      chk("b2b_r_data", DataOut, b2b_val[k]);
      if (k < 3) Addr = 16'h0020 + 16'(2 * (k + 1));
      else       Rd = 1'b0;
      req_cnt++;
    end
    @(posedge clk); #1;

    // Make set 4 fully dirty, then reset during the third write-back cycle
    do_req(16'h0820, 1'b1, 16'h7777, rd, h, s, lat);
    chk("rm_prep_lat", lat, 8);
    Addr = 16'h1020; Rd = 1'b1;
    @(posedge clk); #1;
    Rd = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rm_busy", Stall, 1);
    rst = 1'b0;
    #1;
    chk("rm_stall", Stall, 0);
    chk("rm_done", Done, 0);
    chk("rm_dout", DataOut, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    do_req(16'h1020, 1'b0, 16'h0, rd, h, s, lat);
    chk("rm_rd_data", rd, 16'h0000);
    chk("rm_rd_lat", lat, 8);
    do_req(16'h0020, 1'b0, 16'h0, rd, h, s, lat);
    chk("rm_rd2_data", rd, 16'h0000);

    // Mixed trace on a few conflicting sets; model is a flat word array
    done_cnt = 0;
    req_cnt = 0;
    for (int n = 0; n < 1000; n++) begin
      a = {3'b000, 2'($urandom_range(0, 3)), 6'b000000, 2'($urandom_range(0, 3)),
           2'($urandom_range(0, 3)), 1'($urandom_range(0, 1))};
      d = 16'($urandom);
      w = ($urandom_range(0, 9) < 4);
      do_req(a, w, d, rd, h, s, lat);
      if (w) model[a[15:1]] = d;
      else   chk("rnd_data", rd, model[a[15:1]]);
      exp_lat = h ? 1 : ((lat >= 12) ? 12 : 8);
      chk("rnd_lat", lat, exp_lat);
    end
    chk("done_count", done_cnt, req_cnt);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
